cpu_bus_cycle_timer: RTL and testbench
======================================

Name: cpu_bus_cycle_timer

Overview:
- Bus-side responder to the 65816 CPU controller's per-state memory requests.
- Classifies each access by address region and MEMSEL, then stretches it to 6, 8 or 12 master clocks.
- Drives the external read/write strobes and returns a one-cycle `done` on the final clock.
- Inserts the per-scanline DRAM refresh stall between accesses. Sits between the CPU core and the A-bus decoder.

Parameters:
- FAST_CYCLES, 6, master clocks per fast access and per internal (no-bus) cycle.
- SLOW_CYCLES, 8, master clocks per slow access.
- XSLOW_CYCLES, 12, master clocks per extra-slow access (joypad serial region).
- REFRESH_CYCLES, 40, master clocks per DRAM refresh stall.

Ports:
- clk  in  1  master clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  CPU requests a bus cycle; level; qualified with we/internal/addr.
- we  in  1  1 = write, 0 = read.
- internal  in  1  internal operation: timing only, no strobes.
- addr  in  24  bank:offset of the request.
- memsel_fast  in  1  MEMSEL ($420D) bit 0.
- refresh_req  in  1  one-cycle pulse from the PPU timing block requesting a refresh.
- done  out  1  final clock of the current access; read data is valid this cycle.
- busy  out  1  access or refresh in progress.
- rd_n  out  1  active-low read strobe.
- wr_n  out  1  active-low write strobe.
- bus_addr  out  24  address latched at acceptance.
- refresh_active  out  1  refresh stall in progress.
- cycle_len  out  4  length of the current access in master clocks; 0 when idle.

Behaviour:
- Reset values (asynchronous): state IDLE, counter 0, refresh_pending 0, done 0, busy 0, rd_n 1, wr_n 1, bus_addr 0, refresh_active 0, cycle_len 0.
- States:
  - IDLE.
  - ACCESS: counter 0..N-1.
  - REFRESH: counter 0..REFRESH_CYCLES-1.
- Speed classification (N), for banks 00-3F and 80-BF:
  - offset 0000-1FFF -> SLOW.
  - 2000-3FFF -> FAST.
  - 4000-41FF -> XSLOW.
  - 4200-5FFF -> FAST.
  - 6000-7FFF -> SLOW.
  - 8000-FFFF -> SLOW in banks 00-3F; (memsel_fast ? FAST : SLOW) in banks 80-BF.
- Speed classification, other banks:
  - banks 40-7F -> SLOW.
  - banks C0-FF -> (memsel_fast ? FAST : SLOW).
  - internal=1 -> FAST regardless of address.
- Acceptance point: req is sampled at a rising edge when the state is IDLE, or when done=1 (back-to-back, no gap).
  - On acceptance: latch bus_addr, we, internal and N.
  - Cycle 0 of the new access begins on the next clock.
  - cycle_len=N throughout the access.
- Strobes and completion within ACCESS:
  - For non-internal accesses, rd_n (we=0) or wr_n (we=1) is low for counter 2..N-1 and high at counter 0..1.
  - internal=1: strobes stay high.
  - done=1 exactly at counter N-1.
  - busy=1 for the whole access.
- Refresh:
  - refresh_req sets refresh_pending, in any state.
  - At an acceptance point with refresh_pending=1, REFRESH is entered instead of accepting req; req is not latched.
  - The CPU sees done=0 and keeps req held.
  - During REFRESH: refresh_active=1, busy=1, strobes high, cycle_len=0.
  - refresh_pending clears on entry to REFRESH.
  - At REFRESH_CYCLES-1 the block returns to an acceptance point. The held req is accepted at that edge, and the access starts the next clock.
- Simultaneous refresh_req and acceptance: the pending flag is set first, so refresh wins.
  - A refresh_req arriving during REFRESH re-sets pending, giving one further refresh.
- Inputs changing mid-access (addr, we, internal, memsel_fast) do not affect the current access.
  - memsel_fast is sampled only at acceptance.
- Counter width is 6 bits, enough for 40. The counter never wraps, because the state exits at the terminal count.
- Reset asserted mid-access or mid-refresh: strobes go high immediately and the block is IDLE. A pending refresh is discarded.

Test Plan:
- Read at 00:2100, req held one cycle -> access runs 6 clocks; rd_n low at counters 2-5; done at counter 5; cycle_len=6; bus_addr=002100.
- Write at 80:8000: with memsel_fast=0 -> 8 clocks, wr_n low at counters 2-7; repeat with memsel_fast=1 -> 6 clocks. Read at 00:4016 -> 12 clocks.
- Back-to-back: req held high with addr 7E:0000 then C0:0000 (memsel_fast=0) -> the two 8-clock accesses are contiguous, done pulses 8 clocks apart, with no idle cycle between.
- refresh_req pulsed at counter 3 of a 6-clock read with req held for the next access -> the read completes. Then 40 clocks of refresh_active with done=0. Then the next access starts, with done 40+6 clocks after the first done.
- internal=1 at addr 00:4016 -> 6 clocks, rd_n/wr_n stay high, done at counter 5.
- reset asserted at counter 4 of a 12-clock read -> rd_n=1, busy=0, done=0 asynchronously. After release, a new req is accepted normally.

Source files
------------

// File: rtl/cpu_bus_cycle_timer_if.sv
// Request/response bundle between the 65816 core and the bus cycle timer.
// The timer takes the slave side; the core (or its stand-in) the master side.
interface cpu_bus_cycle_timer_if;
    logic        req;
    logic        we;
    logic        internal;
    logic [23:0] addr;
    logic        memsel_fast;
    logic        refresh_req;
    logic        done;
    logic        busy;
    logic        rd_n;
    logic        wr_n;
    logic [23:0] bus_addr;
    logic        refresh_active;
    logic [3:0]  cycle_len;

    modport slave (
        input  req, we, internal, addr, memsel_fast, refresh_req,
        output done, busy, rd_n, wr_n, bus_addr, refresh_active, cycle_len
    );

    modport master (
        output req, we, internal, addr, memsel_fast, refresh_req,
        input  done, busy, rd_n, wr_n, bus_addr, refresh_active, cycle_len
    );
endinterface

// File: rtl/cpu_bus_cycle_timer.sv
// Stretches CPU bus requests to 6/8/12 master clocks by address region,
// drives the read/write strobes and inserts the DRAM refresh stall.
module cpu_bus_cycle_timer #(
    parameter int FAST_CYCLES    = 6,
    parameter int SLOW_CYCLES    = 8,
    parameter int XSLOW_CYCLES   = 12,
    parameter int REFRESH_CYCLES = 40
) (
    input logic                   clk,
    input logic                   reset,
    cpu_bus_cycle_timer_if.slave  bus
);
    localparam logic [3:0] FAST     = 4'(FAST_CYCLES);
    localparam logic [3:0] SLOW     = 4'(SLOW_CYCLES);
    localparam logic [3:0] XSLOW    = 4'(XSLOW_CYCLES);
    localparam logic [5:0] REF_LAST = 6'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, REFRESH} state_t;

    state_t      state, state_d;
    logic [5:0]  cnt, cnt_d;
    logic [3:0]  len, len_d;
    logic        we_q, we_d;
    logic        int_q, int_d;
    logic        pend, pend_d;
    logic [23:0] addr_q, addr_d;
    logic [3:0]  req_len;
    logic [5:0]  acc_last;
    logic        accept;
    logic        strobe;
    logic        fast_hi;

    assign acc_last = {2'b00, len} - 6'd1;
    // Upper half of banks 80-BF and all of C0-FF follow MEMSEL.
    assign fast_hi  = bus.addr[23] && bus.memsel_fast;

    always_comb begin
        req_len = SLOW;
        if (bus.internal) begin
            req_len = FAST;
        end else if (bus.addr[22]) begin
            req_len = fast_hi ? FAST : SLOW;
        end else begin
            unique case (1'b1)
                bus.addr[15]:
                    req_len = fast_hi ? FAST : SLOW;
                bus.addr[15:13] == 3'b000:
                    req_len = SLOW;
                bus.addr[15:13] == 3'b001:
                    req_len = FAST;
                bus.addr[15:9] == 7'b0100000:
                    req_len = XSLOW;
                bus.addr[15:13] == 3'b010 && bus.addr[12:9] != 4'd0:
                    req_len = FAST;
                bus.addr[15:13] == 3'b011:
                    req_len = SLOW;
                default:
                    req_len = SLOW;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 6'd0;
            len    <= 4'd0;
            we_q   <= 1'b0;
            int_q  <= 1'b0;
            pend   <= 1'b0;
            addr_q <= 24'd0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            len    <= len_d;
            we_q   <= we_d;
            int_q  <= int_d;
            pend   <= pend_d;
            addr_q <= addr_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        len_d   = len;
        we_d    = we_q;
        int_d   = int_q;
        addr_d  = addr_q;
        pend_d  = pend | bus.refresh_req;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                accept = 1'b1;
            end
            ACCESS: begin
                cnt_d  = cnt + 6'd1;
                accept = (cnt == acc_last);
            end
            REFRESH: begin
                cnt_d  = cnt + 6'd1;
                accept = (cnt == REF_LAST);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A refresh raised on this very edge still beats the request.
        if (accept) begin
            cnt_d = 6'd0;
            if (pend_d) begin
                state_d = REFRESH;
                pend_d  = 1'b0;
            end else if (bus.req) begin
                state_d = ACCESS;
                len_d   = req_len;
                we_d    = bus.we;
                int_d   = bus.internal;
                addr_d  = bus.addr;
            end else begin
                state_d = IDLE;
            end
        end
    end

    assign strobe             = (state == ACCESS) && !int_q && (cnt >= 6'd2);
    assign bus.done           = (state == ACCESS) && (cnt == acc_last);
    assign bus.busy           = (state != IDLE);
    assign bus.rd_n           = !(strobe && !we_q);
    assign bus.wr_n           = !(strobe && we_q);
    assign bus.bus_addr       = addr_q;
    assign bus.refresh_active = (state == REFRESH);
    assign bus.cycle_len      = (state == ACCESS) ? len : 4'd0;
endmodule

// File: tb/tb_cpu_bus_cycle_timer.sv
// Random CPU-like traffic and refresh pulses against a transaction-level
// timing model, plus an asynchronous reset taken in the middle of a read.
module tb_cpu_bus_cycle_timer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cpu_bus_cycle_timer_if bus ();

    cpu_bus_cycle_timer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // phase: 0 idle, 1 access, 2 refresh
    int          phase;
    int          elapsed;
    int          len;
    bit          m_we;
    bit          m_int;
    bit          pending;
    logic [23:0] m_addr;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int speed(input logic [23:0] a, input bit in_op,
                                 input bit ms);
        int bank;
        int off;
        bank = int'(a[23:16]);
        off  = int'(a[15:0]);
        if (in_op) return 6;
        if (bank >= 'h40 && bank <= 'h7F) return 8;
        if (bank >= 'hC0) return ms ? 6 : 8;
        if (off < 'h2000) return 8;
        if (off < 'h4000) return 6;
        if (off < 'h4200) return 12;
        if (off < 'h6000) return 6;
        if (off < 'h8000) return 8;
        return (bank >= 'h80 && ms) ? 6 : 8;
    endfunction

    function automatic bit at_accept();
        return phase == 0 ||
               (phase == 1 && elapsed == len - 1) ||
               (phase == 2 && elapsed == 39);
    endfunction

    function automatic logic [23:0] rand_addr();
        logic [7:0]  b;
        logic [15:0] o;
        case ($urandom_range(0, 8))
            0: b = 8'h00;
            1: b = 8'h3F;
            2: b = 8'h40;
            3: b = 8'h7E;
            4: b = 8'h80;
            5: b = 8'hBF;
            6: b = 8'hC0;
            7: b = 8'hFF;
            default: b = 8'($urandom_range(0, 255));
        endcase
        case ($urandom_range(0, 14))
            0: o = 16'h0000;
            1: o = 16'h1FFF;
            2: o = 16'h2000;
            3: o = 16'h2100;
            4: o = 16'h3FFF;
            5: o = 16'h4000;
            6: o = 16'h4016;
            7: o = 16'h41FF;
            8: o = 16'h4200;
            9: o = 16'h5FFF;
            10: o = 16'h6000;
            11: o = 16'h7FFF;
            12: o = 16'h8000;
            13: o = 16'hFFFF;
            default: o = 16'($urandom_range(0, 65535));
        endcase
        return {b, o};
    endfunction

    task automatic model_reset();
        phase   = 0;
        elapsed = 0;
        len     = 0;
        m_we    = 1'b0;
        m_int   = 1'b0;
        pending = 1'b0;
        m_addr  = 24'd0;
    endtask

    // Compare this cycle, advance the model over the coming edge, step.
    task automatic tick();
        bit e_done;
        bit e_strobe;
        bit pend_now;
        e_done   = (phase == 1) && (elapsed == len - 1);
        e_strobe = (phase == 1) && !m_int && (elapsed >= 2);
        check("done", bus.done, e_done);
        check("busy", bus.busy, phase != 0);
        check("rd_n", bus.rd_n, !(e_strobe && !m_we));
        check("wr_n", bus.wr_n, !(e_strobe && m_we));
        check("bus_addr", bus.bus_addr, m_addr);
        check("refresh_active", bus.refresh_active, phase == 2);
        check("cycle_len", bus.cycle_len, (phase == 1) ? len : 0);
        pend_now = pending || bus.refresh_req;
        if (at_accept()) begin
            elapsed = 0;
            if (pend_now) begin
                phase   = 2;
                pending = 1'b0;
            end else if (bus.req) begin
                phase  = 1;
                len    = speed(bus.addr, bus.internal, bus.memsel_fast);
                m_we   = bus.we;
                m_int  = bus.internal;
                m_addr = bus.addr;
            end else begin
                phase = 0;
            end
        end else begin
            elapsed++;
            pending = pend_now;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset           = 1'b1;
        bus.req         = 1'b0;
        bus.we          = 1'b0;
        bus.internal    = 1'b0;
        bus.addr        = 24'd0;
        bus.memsel_fast = 1'b0;
        bus.refresh_req = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            if (at_accept()) begin
                bus.req = ($urandom_range(0, 3) != 0);
                bus.addr        = rand_addr();
                bus.we          = 1'($urandom_range(0, 1));
                bus.internal    = ($urandom_range(0, 4) == 0);
                bus.memsel_fast = 1'($urandom_range(0, 1));
            end else if ($urandom_range(0, 1) == 1) begin
                bus.req         = 1'($urandom_range(0, 1));
                bus.addr        = rand_addr();
                bus.we          = 1'($urandom_range(0, 1));
                bus.internal    = 1'($urandom_range(0, 1));
                bus.memsel_fast = 1'($urandom_range(0, 1));
            end
            bus.refresh_req = ($urandom_range(0, 49) == 0);
            tick();
        end

        bus.req         = 1'b0;
        bus.refresh_req = 1'b0;
        for (int i = 0; i < 100 && phase != 0; i++) tick();
        check("drain_busy", bus.busy, 1'b0);

        bus.req      = 1'b1;
        bus.addr     = 24'h004016;
        bus.we       = 1'b0;
        bus.internal = 1'b0;
        tick();
        bus.req = 1'b0;
        repeat (4) tick();
        check("pre_reset_rd_n", bus.rd_n, 1'b0);
        reset = 1'b1;
        #1;
        check("async_rd_n", bus.rd_n, 1'b1);
        check("async_busy", bus.busy, 1'b0);
        check("async_done", bus.done, 1'b0);
        check("async_cycle_len", bus.cycle_len, 4'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        bus.req  = 1'b1;
        bus.addr = 24'h002100;
        tick();
        bus.req = 1'b0;
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
